// File: rtl/rv_iopmp_cfg_reg_guard.sv
// Registered guard between the IOPMP config AXI-to-reg bridge and the IOPMP register file.
// Rejects out-of-range, misaligned or partial-strobe accesses, bounds downstream waits, keeps error bookkeeping.
package rv_iopmp_cfg_reg_guard_pkg;
  typedef struct packed {
    logic [63:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

module rv_iopmp_cfg_reg_guard #(
  parameter int unsigned                ADDR_WIDTH     = 64,
  parameter int unsigned                REG_DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]      CFG_SIZE       = 'h4000,
  parameter int unsigned                TIMEOUT        = 64,
  parameter bit                         FULL_WORD_ONLY = 1'b1,
  parameter type                        reg_req_t      = rv_iopmp_cfg_reg_guard_pkg::reg_req_t,
  parameter type                        reg_rsp_t      = rv_iopmp_cfg_reg_guard_pkg::reg_rsp_t
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  reg_req_t              slv_req_i,
  output reg_rsp_t              slv_rsp_o,
  output reg_req_t              mst_req_o,
  input  reg_rsp_t              mst_rsp_i,
  input  logic                  err_clr_i,
  output logic                  err_o,
  output logic [1:0]            err_cause_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
  output logic [15:0]           err_cnt_o
);
  localparam int unsigned STRB_W = REG_DATA_WIDTH / 8;
  localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] C_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_RESP} state_e;

  state_e                    r_state;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic                      r_write;
  logic [REG_DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]         r_wstrb;
  logic                      r_mst_valid;
  logic [CNT_W-1:0]          r_wait;
  logic                      r_rsp_ready;
  logic                      r_rsp_error;
  logic [REG_DATA_WIDTH-1:0] r_rsp_rdata;

  logic                      r_err;
  logic [1:0]                r_err_cause;
  logic [1:0]                r_cur_cause;
  logic [ADDR_WIDTH-1:0]     r_err_addr;
  logic [15:0]               r_err_cnt;

  logic [1:0]                w_chk_cause;
  logic                      w_idle_req;
  logic                      w_fwd;
  logic                      w_tmo_hit;
  logic                      w_dn_err;
  logic                      w_new_err;
  logic [1:0]                w_new_cause;
  logic [ADDR_WIDTH-1:0]     w_new_addr;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Guard checks in priority order: range, alignment, partial-strobe write
  always_comb begin
    w_chk_cause = 2'd0;
    if (slv_req_i.addr >= CFG_SIZE) begin
      w_chk_cause = 2'd1;
    end else if (slv_req_i.addr[1:0] != 2'b00) begin
      w_chk_cause = 2'd2;
    end else if (FULL_WORD_ONLY && slv_req_i.write && (slv_req_i.wstrb != {STRB_W{1'b1}})) begin
      w_chk_cause = 2'd2;
    end
  end

  assign w_idle_req  = (r_state == ST_IDLE) && slv_req_i.valid;
  assign w_fwd       = (r_state == ST_FWD);
  assign w_tmo_hit   = w_fwd && !mst_rsp_i.ready && (TIMEOUT != 0) && (r_wait == C_LAST);
  assign w_dn_err    = w_fwd && mst_rsp_i.ready && mst_rsp_i.error;
  assign w_new_err   = (w_idle_req && (w_chk_cause != 2'd0)) || w_tmo_hit || w_dn_err;
  assign w_new_cause = w_idle_req ? w_chk_cause : (w_tmo_hit ? 2'd3 : 2'd0);
  assign w_new_addr  = w_idle_req ? slv_req_i.addr : r_addr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_mst_valid <= 1'b0;
      r_wait      <= '0;
      r_rsp_ready <= 1'b0;
      r_rsp_error <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (slv_req_i.valid) begin
            r_addr  <= slv_req_i.addr;
            r_write <= slv_req_i.write;
            r_wdata <= slv_req_i.wdata;
            r_wstrb <= slv_req_i.wstrb;
            r_wait  <= '0;
            if (w_chk_cause != 2'd0) begin
              r_rsp_ready <= 1'b1;
              r_rsp_error <= 1'b1;
              r_rsp_rdata <= '0;
              r_state     <= ST_RESP;
            end else begin
              r_mst_valid <= 1'b1;
              r_state     <= ST_FWD;
            end
          end
        end
        ST_FWD: begin
          // Downstream ready takes precedence over an expiring timeout
          if (mst_rsp_i.ready) begin
            r_mst_valid <= 1'b0;
            r_rsp_ready <= 1'b1;
            r_rsp_error <= mst_rsp_i.error;
            r_rsp_rdata <= r_write ? '0 : mst_rsp_i.rdata;
            r_state     <= ST_RESP;
          end else if (w_tmo_hit) begin
            r_mst_valid <= 1'b0;
            r_rsp_ready <= 1'b1;
            r_rsp_error <= 1'b1;
            r_rsp_rdata <= '0;
            r_state     <= ST_RESP;
          end else begin
            r_wait <= r_wait + CNT_W'(1);
          end
        end
        ST_RESP: begin
          r_rsp_ready <= 1'b0;
          r_rsp_error <= 1'b0;
          r_rsp_rdata <= '0;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_mst_valid <= 1'b0;
          r_rsp_ready <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Bookkeeping is written on the edge entering an error RESP; a clear seen during that RESP keeps it as the sole error
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err       <= 1'b0;
      r_err_cause <= 2'd0;
      r_cur_cause <= 2'd0;
      r_err_addr  <= '0;
      r_err_cnt   <= 16'd0;
    end else if (w_new_err) begin
      r_err       <= 1'b1;
      r_cur_cause <= w_new_cause;
      r_err_addr  <= w_new_addr;
      r_err_cnt   <= err_clr_i ? 16'd1 : sat_inc(r_err_cnt);
      if (w_new_cause != 2'd0) begin
        r_err_cause <= w_new_cause;
      end else if (err_clr_i) begin
        r_err_cause <= 2'd0;
      end
    end else begin
      r_err <= 1'b0;
      if (err_clr_i) begin
        if (r_err) begin
          r_err_cnt   <= 16'd1;
          r_err_cause <= r_cur_cause;
        end else begin
          r_err_cnt   <= 16'd0;
          r_err_cause <= 2'd0;
          r_err_addr  <= '0;
        end
      end
    end
  end

  always_comb begin
    mst_req_o       = '0;
    mst_req_o.addr  = r_addr;
    mst_req_o.write = r_write;
    mst_req_o.wdata = r_wdata;
    mst_req_o.wstrb = r_wstrb;
    mst_req_o.valid = r_mst_valid;
    slv_rsp_o       = '0;
    slv_rsp_o.rdata = r_rsp_rdata;
    slv_rsp_o.error = r_rsp_error;
    slv_rsp_o.ready = r_rsp_ready;
  end

  assign err_o       = r_err;
  assign err_cause_o = r_err_cause;
  assign err_addr_o  = r_err_addr;
  assign err_cnt_o   = r_err_cnt;

endmodule

// File: tb/tb_rv_iopmp_cfg_reg_guard.sv
// Bench for rv_iopmp_cfg_reg_guard: directed vector table, corner sequences and
// randomized accesses checked against an access-level reference model.
module tb_rv_iopmp_cfg_reg_guard;
  import rv_iopmp_cfg_reg_guard_pkg::*;

  localparam int          TO    = 4;
  localparam logic [63:0] CFG   = 64'h4000;
  localparam int          NEVER = 99;

  logic        clk = 1'b0;
  logic        rst_ni;
  reg_req_t    slv_req;
  reg_rsp_t    slv_rsp;
  reg_req_t    mst_req;
  reg_rsp_t    mst_rsp;
  logic        err_clr;
  logic        err;
  logic [1:0]  err_cause;
  logic [63:0] err_addr;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  rv_iopmp_cfg_reg_guard #(
    .ADDR_WIDTH    (64),
    .REG_DATA_WIDTH(32),
    .CFG_SIZE      (64'h4000),
    .TIMEOUT       (TO),
    .FULL_WORD_ONLY(1'b1)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .slv_req_i  (slv_req),
    .slv_rsp_o  (slv_rsp),
    .mst_req_o  (mst_req),
    .mst_rsp_i  (mst_rsp),
    .err_clr_i  (err_clr),
    .err_o      (err),
    .err_cause_o(err_cause),
    .err_addr_o (err_addr),
    .err_cnt_o  (err_cnt)
  );

  typedef struct {
    logic [63:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          ds_wait;
    logic [31:0] ds_rdata;
    logic        ds_err;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
    logic [1:0]  exp_cause;
    logic [15:0] exp_cnt;
    logic [63:0] exp_addr;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  int          m_cnt;
  logic [1:0]  m_cause;
  logic [63:0] m_addr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Access-level reference: outcome decided from the access attributes alone
  task automatic model_access(input logic [63:0] a, input logic w, input logic [3:0] s,
                              input int dw, input logic [31:0] dr, input logic de,
                              output logic e_err, output logic [31:0] e_rd, output int e_lat,
                              output int e_mc, output logic [1:0] e_cause);
    e_cause = 2'd0;
    if (a >= CFG) e_cause = 2'd1;
    else if (a % 4 != 0) e_cause = 2'd2;
    else if (w && s != 4'hF) e_cause = 2'd2;
    if (e_cause != 2'd0) begin
      e_err = 1'b1; e_rd = '0; e_lat = 1; e_mc = 0;
    end else if (dw < TO) begin
      e_err = de; e_rd = w ? 32'd0 : dr; e_lat = 2 + dw; e_mc = dw + 1;
    end else begin
      e_cause = 2'd3; e_err = 1'b1; e_rd = '0; e_lat = TO + 1; e_mc = TO;
    end
    if (e_err) begin
      m_cnt  = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
      m_addr = a;
      if (e_cause != 2'd0) m_cause = e_cause;
    end
  endtask

  task automatic run_access(input logic [63:0] a, input logic w, input logic [31:0] wd,
                            input logic [3:0] s, input int dw, input logic [31:0] dr,
                            input logic de, input bit clr,
                            output logic g_done, output logic g_paybad, output logic [31:0] g_rd,
                            output logic g_err, output int g_lat, output int g_mc,
                            output logic g_pulse, output logic [1:0] g_cause,
                            output logic [15:0] g_cnt, output logic [63:0] g_addr);
    g_done = 0; g_paybad = 0; g_rd = '0; g_err = 0; g_lat = 0; g_mc = 0;
    g_pulse = 0; g_cause = '0; g_cnt = '0; g_addr = '0;
    @(negedge clk);
    slv_req.addr = a; slv_req.write = w; slv_req.wdata = wd; slv_req.wstrb = s;
    slv_req.valid = 1'b1;
    mst_rsp = '0;
    for (int c = 1; c <= TO + 8; c++) begin
      @(negedge clk);
      mst_rsp = '0;
      if (mst_req.valid) begin
        g_mc++;
        if (mst_req.addr !== a || mst_req.write !== w || mst_req.wdata !== wd || mst_req.wstrb !== s)
          g_paybad = 1;
        if (g_mc - 1 == dw) begin
          mst_rsp.ready = 1'b1; mst_rsp.rdata = dr; mst_rsp.error = de;
        end
      end
      if (slv_rsp.ready) begin
        g_done = 1; g_lat = c; g_rd = slv_rsp.rdata; g_err = slv_rsp.error;
        g_pulse = err; g_cause = err_cause; g_cnt = err_cnt; g_addr = err_addr;
        break;
      end
    end
    if (clr) err_clr = 1'b1;
    @(posedge clk);
    #1;
    slv_req.valid = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic exec(input vec_t v, input bit clr, input bit use_tbl, input string tag);
    logic e_err; logic [31:0] e_rd; int e_lat, e_mc; logic [1:0] e_cause;
    logic g_done, g_paybad, g_err, g_pulse; logic [31:0] g_rd; int g_lat, g_mc;
    logic [1:0] g_cause; logic [15:0] g_cnt; logic [63:0] g_addr;
    model_access(v.addr, v.write, v.wstrb, v.ds_wait, v.ds_rdata, v.ds_err,
                 e_err, e_rd, e_lat, e_mc, e_cause);
    run_access(v.addr, v.write, v.wdata, v.wstrb, v.ds_wait, v.ds_rdata, v.ds_err, clr,
               g_done, g_paybad, g_rd, g_err, g_lat, g_mc, g_pulse, g_cause, g_cnt, g_addr);
    chk($sformatf("%s.done", tag), 64'(g_done), 64'(1));
    chk($sformatf("%s.payload", tag), 64'(g_paybad), 64'(0));
    chk($sformatf("%s.mst_cycles", tag), 64'(g_mc), 64'(e_mc));
    chk($sformatf("%s.err_o", tag), 64'(g_pulse), 64'(e_err));
    if (use_tbl) begin
      chk($sformatf("%s.error", tag), 64'(g_err), 64'(v.exp_err));
      chk($sformatf("%s.rdata", tag), 64'(g_rd), 64'(v.exp_rdata));
      chk($sformatf("%s.latency", tag), 64'(g_lat), 64'(v.exp_lat));
      chk($sformatf("%s.err_cause", tag), 64'(g_cause), 64'(v.exp_cause));
      chk($sformatf("%s.err_cnt", tag), 64'(g_cnt), 64'(v.exp_cnt));
      chk($sformatf("%s.err_addr", tag), g_addr, v.exp_addr);
    end else begin
      chk($sformatf("%s.error", tag), 64'(g_err), 64'(e_err));
      chk($sformatf("%s.rdata", tag), 64'(g_rd), 64'(e_rd));
      chk($sformatf("%s.latency", tag), 64'(g_lat), 64'(e_lat));
      chk($sformatf("%s.err_cause", tag), 64'(g_cause), 64'(m_cause));
      chk($sformatf("%s.err_cnt", tag), 64'(g_cnt), 64'(m_cnt));
      chk($sformatf("%s.err_addr", tag), g_addr, m_addr);
    end
    if (clr) begin
      if (e_err) begin
        m_cnt = 1; m_cause = e_cause;
      end else begin
        m_cnt = 0; m_cause = 2'd0; m_addr = '0;
      end
      chk($sformatf("%s.clr_cnt", tag), 64'(err_cnt), 64'(m_cnt));
      chk($sformatf("%s.clr_cause", tag), 64'(err_cause), 64'(m_cause));
      chk($sformatf("%s.clr_addr", tag), err_addr, m_addr);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk($sformatf("%s.mst_valid", tag), 64'(mst_req.valid), 64'(0));
    chk($sformatf("%s.mst_addr", tag), mst_req.addr, 64'(0));
    chk($sformatf("%s.slv_ready", tag), 64'(slv_rsp.ready), 64'(0));
    chk($sformatf("%s.slv_error", tag), 64'(slv_rsp.error), 64'(0));
    chk($sformatf("%s.slv_rdata", tag), 64'(slv_rsp.rdata), 64'(0));
    chk($sformatf("%s.err_o", tag), 64'(err), 64'(0));
    chk($sformatf("%s.err_cause", tag), 64'(err_cause), 64'(0));
    chk($sformatf("%s.err_addr", tag), err_addr, 64'(0));
    chk($sformatf("%s.err_cnt", tag), 64'(err_cnt), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vec_t tbl[13];
    vec_t v;
    int   r;
    bit   clr;

    tbl[0]  = '{64'h10,   1'b0, 32'h0,    4'hF, 0,     32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF, 2, 2'd0, 16'd0, 64'h0};
    tbl[1]  = '{64'h4000, 1'b1, 32'h1234, 4'hF, 0,     32'h0,        1'b0, 1'b1, 32'h0,        1, 2'd1, 16'd1, 64'h4000};
    tbl[2]  = '{64'h8,    1'b1, 32'h55,   4'h3, 0,     32'h0,        1'b0, 1'b1, 32'h0,        1, 2'd2, 16'd2, 64'h8};
    tbl[3]  = '{64'h6,    1'b0, 32'h0,    4'hF, 0,     32'h0,        1'b0, 1'b1, 32'h0,        1, 2'd2, 16'd3, 64'h6};
    tbl[4]  = '{64'h20,   1'b0, 32'h0,    4'hF, NEVER, 32'h0,        1'b0, 1'b1, 32'h0,        5, 2'd3, 16'd4, 64'h20};
    tbl[5]  = '{64'h24,   1'b1, 32'hAA55, 4'hF, 3,     32'hFFFFFFFF, 1'b0, 1'b0, 32'h0,        5, 2'd3, 16'd4, 64'h20};
    tbl[6]  = '{64'h3FFC, 1'b0, 32'h0,    4'hF, 1,     32'h12345678, 1'b0, 1'b0, 32'h12345678, 3, 2'd3, 16'd4, 64'h20};
    tbl[7]  = '{64'h100,  1'b0, 32'h0,    4'hF, 0,     32'hCAFEF00D, 1'b1, 1'b1, 32'hCAFEF00D, 2, 2'd3, 16'd5, 64'h100};
    tbl[8]  = '{64'h3FFF, 1'b1, 32'h0,    4'hF, 0,     32'h0,        1'b0, 1'b1, 32'h0,        1, 2'd2, 16'd6, 64'h3FFF};
    tbl[9]  = '{64'h4001, 1'b1, 32'h0,    4'h1, 0,     32'h0,        1'b0, 1'b1, 32'h0,        1, 2'd1, 16'd7, 64'h4001};
    tbl[10] = '{64'h0,    1'b1, 32'h77,   4'h0, 0,     32'h0,        1'b0, 1'b1, 32'h0,        1, 2'd2, 16'd8, 64'h0};
    tbl[11] = '{64'h4,    1'b0, 32'h0,    4'h0, 2,     32'h0BADF00D, 1'b0, 1'b0, 32'h0BADF00D, 4, 2'd2, 16'd8, 64'h0};
    tbl[12] = '{64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 32'h0, 4'hF, 0, 32'h0, 1'b0, 1'b1, 32'h0, 1, 2'd1, 16'd9, 64'hFFFF_FFFF_FFFF_FFF0};

    rst_ni = 1'b0; slv_req = '0; mst_rsp = '0; err_clr = 1'b0;
    m_cnt = 0; m_cause = 2'd0; m_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_ni = 1'b1;

    for (int i = 0; i < 13; i++) exec(tbl[i], 1'b0, 1'b1, $sformatf("tbl%0d", i));

    // Clear while idle
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    m_cnt = 0; m_cause = 2'd0; m_addr = '0;
    chk("idle_clr.cnt", 64'(err_cnt), 64'(0));
    chk("idle_clr.cause", 64'(err_cause), 64'(0));
    chk("idle_clr.addr", err_addr, 64'(0));

    // Clear coinciding with error responses
    v = tbl[1];
    exec(v, 1'b0, 1'b0, "pre_clr");
    exec(v, 1'b1, 1'b0, "clr_guard");
    v = tbl[7];
    exec(v, 1'b1, 1'b0, "clr_dnerr");

    for (int i = 0; i < 120; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6)       v.addr = 64'($urandom_range(0, 'hFFF)) << 2;
      else if (r < 8)  v.addr = 64'($urandom_range(0, 'h3FFF)) | 64'(($urandom_range(1, 3)));
      else if (r == 8) v.addr = CFG + 64'($urandom_range(0, 64));
      else             v.addr = {$urandom, $urandom};
      v.write    = 1'($urandom_range(0, 1));
      v.wdata    = $urandom;
      v.wstrb    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      v.ds_wait  = int'($urandom_range(0, TO + 1));
      v.ds_rdata = $urandom;
      v.ds_err   = ($urandom_range(0, 7) == 0);
      clr        = ($urandom_range(0, 9) == 0);
      exec(v, clr, 1'b0, $sformatf("rnd%0d", i));
    end

    // Saturation at 16'hFFFF
    @(negedge clk);
    dut.r_err_cnt = 16'hFFFE;
    m_cnt = 65534;
    @(negedge clk);
    chk("sat.preset", 64'(err_cnt), 64'hFFFE);
    v = tbl[9];
    exec(v, 1'b0, 1'b0, "sat1");
    exec(v, 1'b0, 1'b0, "sat2");
    chk("sat.hold", 64'(err_cnt), 64'hFFFF);
    exec(v, 1'b1, 1'b0, "sat_clr");

    // Reset asserted while a request is being forwarded
    @(negedge clk);
    slv_req.addr = 64'h30; slv_req.write = 1'b0; slv_req.wdata = '0; slv_req.wstrb = 4'hF;
    slv_req.valid = 1'b1;
    mst_rsp = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_fwd.mst_valid_before", 64'(mst_req.valid), 64'(1));
    rst_ni = 1'b0;
    #1;
    chk_all_zero("rst_fwd");
    slv_req.valid = 1'b0;
    m_cnt = 0; m_cause = 2'd0; m_addr = '0;
    @(negedge clk);
    rst_ni = 1'b1;
    exec(tbl[0], 1'b0, 1'b0, "post_rst");
    exec(tbl[4], 1'b0, 1'b0, "post_rst_tmo");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
